run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/run_controller.sv | 137 +++++++++++++
 tb/tb_run_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        TOUT = 3'd4
    } run_state_t;

    // Address the program stores to when it finishes.
    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_0FFC;
    // Exit value that reports a passing program.
    localparam logic [31:0] PASS_CODE      = 32'h0000_0001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and an enable.
// The counter holds at all-ones and never wraps.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear wins over counting; increments stop at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/run_controller.sv
// Run controller: holds the CPU in reset for a programmable number of
// cycles after start, then runs it until it stores to the tohost address
// or, when RUN_CONTROLLER_WATCHDOG_EN is defined, the watchdog expires.
// Without RUN_CONTROLLER_WATCHDOG_EN the TOUT state is never entered
// and timeout is tied low.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int          RESET_CYCLES   = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_DEFAULT,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             instr_retire,
    input  logic             memory_write_en,
    input  logic [31:0]      memory_write_address,
    input  logic [31:0]      memory_write,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [31:0]      exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    // Wide enough to hold RESET_CYCLES-1, and at least one bit.
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    run_state_t        state, next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              clr;
    logic              tohost_hit;
    logic              wd_hit;
    logic              in_run;

    assign in_run     = (state == RUN);
    assign tohost_hit = memory_write_en && (memory_write_address == TOHOST_ADDR);

`ifdef RUN_CONTROLLER_WATCHDOG_EN
    assign wd_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; a tohost hit beats a watchdog expiry in the same cycle.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        case (state)
            IDLE, DONE, TOUT: begin
                if (start) begin
                    next_state = HOLD;
                    clr        = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == '0)
                    next_state = RUN;
            end
            RUN: begin
                if (tohost_hit)
                    next_state = DONE;
                else if (wd_hit)
                    next_state = TOUT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Hold counter, exit code and pass flag; all cleared by a new start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            exit_code <= '0;
            pass      <= 1'b0;
        end else if (clr) begin
            hold_cnt  <= HOLD_W'(RESET_CYCLES - 1);
            exit_code <= '0;
            pass      <= 1'b0;
        end else begin
            if ((state == HOLD) && (hold_cnt != '0))
                hold_cnt <= hold_cnt - 1'b1;
            if (in_run && tohost_hit) begin
                exit_code <= memory_write;
                pass      <= (memory_write == PASS_CODE);
            end
        end
    end

`ifdef RUN_CONTROLLER_WATCHDOG_EN
    // Timeout flag is set only when the watchdog wins over a tohost hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timeout <= 1'b0;
        else if (clr)
            timeout <= 1'b0;
        else if (in_run && !tohost_hit && wd_hit)
            timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign cpu_reset = !in_run;
    assign running   = in_run;
    assign done      = (state == DONE) || (state == TOUT);

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (in_run),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (in_run && instr_retire),
        .count (retire_count)
    );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller (RESET_CYCLES=2, TIMEOUT_CYCLES=16),
// plus a narrow sat_counter to reach saturation quickly.
module tb_run_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        instr_retire = 1'b0;
    logic        memory_write_en = 1'b0;
    logic [31:0] memory_write_address = '0;
    logic [31:0] memory_write = '0;
    logic        cpu_reset, running, done, pass, timeout;
    logic [31:0] exit_code, cycle_count, retire_count;

    logic       sclr = 1'b0;
    logic       sen  = 1'b0;
    logic [2:0] scnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_controller #(
        .RESET_CYCLES   (2),
        .TIMEOUT_CYCLES (16),
        .TOHOST_ADDR    (32'h0000_0FFC),
        .CNT_W          (32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .instr_retire         (instr_retire),
        .memory_write_en      (memory_write_en),
        .memory_write_address (memory_write_address),
        .memory_write         (memory_write),
        .cpu_reset            (cpu_reset),
        .running              (running),
        .done                 (done),
        .pass                 (pass),
        .timeout              (timeout),
        .exit_code            (exit_code),
        .cycle_count          (cycle_count),
        .retire_count         (retire_count)
    );

    sat_counter #(.WIDTH(3)) u_sat (
        .clk   (clk),
        .reset (reset),
        .clr   (sclr),
        .en    (sen),
        .count (scnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 10 && !running; i++) tick();
        chk(tag, running, 1);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memory_write_en      = 1'b1;
        memory_write_address = addr;
        memory_write         = data;
        tick();
        memory_write_en      = 1'b0;
    endtask

    initial begin
        int hc;
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_exit", exit_code, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_retire", retire_count, 0);
        reset = 1'b1;

        // Run 1: hold length, retires, ignored store, passing tohost store
        pulse_start();
        hc = 0;
        while (cpu_reset && hc < 10) begin
            hc++;
            tick();
        end
        chk("hold_cycles", hc, 2);
        chk("run1_running", running, 1);
        chk("run1_cycles0", cycle_count, 0);
        instr_retire = 1'b1;
        repeat (5) tick();
        instr_retire = 1'b0;
        store(32'h0000_0FF8, 32'h1);
        chk("ff8_running", running, 1);
        chk("ff8_done", done, 0);
        store(32'h0000_0FFC, 32'h1);
        chk("run1_done", done, 1);
        chk("run1_pass", pass, 1);
        chk("run1_exit", exit_code, 1);
        chk("run1_retire", retire_count, 5);
        chk("run1_cycles", cycle_count, 7);
        chk("run1_cpu_reset", cpu_reset, 1);
        instr_retire = 1'b1;
        store(32'h0000_0FFC, 32'h5);
        instr_retire = 1'b0;
        chk("done_hold_retire", retire_count, 5);
        chk("done_hold_exit", exit_code, 1);

        // Run 2: restart from DONE, start ignored in RUN, failing exit code
        pulse_start();
        chk("run2_clr_done", done, 0);
        chk("run2_clr_retire", retire_count, 0);
        chk("run2_clr_exit", exit_code, 0);
        chk("run2_clr_pass", pass, 0);
        wait_run("run2_wait");
        pulse_start();
        chk("run2_start_ign", running, 1);
        chk("run2_cycles1", cycle_count, 1);
        store(32'h0000_0FFC, 32'h0000_002B);
        chk("run2_done", done, 1);
        chk("run2_pass", pass, 0);
        chk("run2_exit", exit_code, 32'h2B);

        // Run 3: no tohost store
        pulse_start();
        wait_run("run3_wait");
`ifdef RUN_CONTROLLER_WATCHDOG_EN
        n = 0;
        while (!done && n < 40) begin
            n++;
            tick();
        end
        chk("tout_cycles_run", n, 16);
        chk("tout_done", done, 1);
        chk("tout_timeout", timeout, 1);
        chk("tout_cycle_count", cycle_count, 16);
        chk("tout_cpu_reset", cpu_reset, 1);
        chk("tout_pass", pass, 0);
`else
        n = 0;
        repeat (20) begin
            n++;
            tick();
        end
        chk("nowd_running", running, 1);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_cycles", cycle_count, n);
        store(32'h0000_0FFC, 32'h1);
        chk("nowd_done", done, 1);
`endif

        // Run 4: tohost store on the watchdog cycle wins
        pulse_start();
        wait_run("run4_wait");
        repeat (15) tick();
        chk("tie_cycles15", cycle_count, 15);
        store(32'h0000_0FFC, 32'h1);
        chk("tie_done", done, 1);
        chk("tie_timeout", timeout, 0);
        chk("tie_pass", pass, 1);

        // Run 5: reset asserted mid-run, then a clean re-run
        pulse_start();
        wait_run("run5_wait");
        instr_retire = 1'b1;
        repeat (3) tick();
        instr_retire = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_running", running, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_cycles", cycle_count, 0);
        chk("mid_rst_retire", retire_count, 0);
        chk("mid_rst_done", done, 0);
        tick();
        reset = 1'b1;
        pulse_start();
        wait_run("rerun_wait");
        chk("rerun_cycles", cycle_count, 0);
        instr_retire = 1'b1;
        repeat (2) tick();
        instr_retire = 1'b0;
        chk("rerun_retire", retire_count, 2);

        // Saturation on a 3-bit counter
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sat_clr", scnt, 0);
        sen = 1'b1;
        repeat (6) tick();
        chk("sat_6", scnt, 6);
        repeat (3) tick();
        chk("sat_hold", scnt, 7);
        sen  = 1'b0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sat_clr2", scnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
